// File: rtl/usb_tx_engine.sv
// usb_tx_engine: full-speed USB packet serialiser (SYNC, PID, payload, CRC16,
//   bit stuffing, NRZI, EOP) running on clk with an internal bit-rate divider.
// Latency: first SYNC bit drives the lines one cycle after an accepted tx_start.
// Backpressure: none; payload bytes are pulled with get_tx_packet_data and
//   tx_start is ignored while a packet is in flight.
// Ports: clk/n_rst (async active-low); tx_start/tx_pid/tx_packet_size request;
//   tx_packet_data + get_tx_packet_data FIFO head and pop strobe;
//   dplus_out/dminus_out line drive; tx_transfer_active, tx_done, tx_error status.
module usb_tx_engine #(
  parameter int CLK_DIV     = 8,
  parameter int MAX_PAYLOAD = 64,
  parameter int SIZE_W      = $clog2(MAX_PAYLOAD + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              tx_start,
  input  logic [3:0]        tx_pid,
  input  logic [SIZE_W-1:0] tx_packet_size,
  input  logic [7:0]        tx_packet_data,
  output logic              get_tx_packet_data,
  output logic              dplus_out,
  output logic              dminus_out,
  output logic              tx_transfer_active,
  output logic              tx_done,
  output logic              tx_error
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SIZE_W-1:0] MAX_SZ   = SIZE_W'(MAX_PAYLOAD);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP} state_t;

  state_t            state, state_nxt;
  logic [3:0]        bit_idx, bit_idx_nxt, bit_inc;
  logic [DIV_W-1:0]  div_cnt;
  logic [SIZE_W-1:0] byte_cnt, size_q;
  logic [3:0]        pid_q;
  logic [7:0]        byte_q, pid_byte;
  logic [15:0]       crc;
  logic [2:0]        ones;
  logic              nrzi_j;   // NRZI line level, 1 = J
  logic              done_q, err_q;

  logic bit_end, stuff_ins, adv, raw_bit, load_byte, req_ok, accept, crc_fb;

  assign bit_inc  = bit_idx + 4'd1;
  assign bit_end  = (div_cnt == DIV_LAST);
  assign pid_byte = {~pid_q, pid_q};
  assign crc_fb   = crc[15] ^ raw_bit;
  assign accept   = (state == S_IDLE) && tx_start && req_ok;

  always_comb begin
    req_ok = 1'b0;
    case (tx_pid)
      4'b0011, 4'b1011:         req_ok = (tx_packet_size <= MAX_SZ);
      4'b0010, 4'b1010, 4'b1110: req_ok = (tx_packet_size == '0);
      default:                  req_ok = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= S_IDLE;
      bit_idx <= 4'd0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_idx_nxt;
    end
  end

  // Next-state: at each bit boundary either insert a stuff bit (position
  // holds) or advance to the next raw bit and compute its value.
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    raw_bit     = 1'b0;
    adv         = 1'b0;
    load_byte   = 1'b0;
    stuff_ins   = 1'b0;
    if (state == S_IDLE) begin
      if (accept) begin
        state_nxt   = S_SYNC;
        bit_idx_nxt = 4'd0;
      end
    end else if (bit_end) begin
      if (state != S_EOP && ones == 3'd6) begin
        stuff_ins = 1'b1;
      end else begin
        adv         = 1'b1;
        bit_idx_nxt = bit_inc;
        case (state)
          S_SYNC: begin
            if (bit_idx == 4'd7) begin
              state_nxt   = S_PID;
              bit_idx_nxt = 4'd0;
              raw_bit     = pid_byte[0];
            end else begin
              raw_bit = (bit_idx == 4'd6);
            end
          end
          S_PID: begin
            if (bit_idx == 4'd7) begin
              bit_idx_nxt = 4'd0;
              if (pid_q[1:0] == 2'b10) begin
                state_nxt = S_EOP;
              end else if (size_q == '0) begin
                state_nxt = S_CRC;
                raw_bit   = ~crc[15];
              end else begin
                state_nxt = S_DATA;
                load_byte = 1'b1;
                raw_bit   = tx_packet_data[0];
              end
            end else begin
              raw_bit = pid_byte[bit_inc[2:0]];
            end
          end
          S_DATA: begin
            if (bit_idx == 4'd7) begin
              bit_idx_nxt = 4'd0;
              if (byte_cnt == size_q) begin
                state_nxt = S_CRC;
                raw_bit   = ~crc[15];
              end else begin
                load_byte = 1'b1;
                raw_bit   = tx_packet_data[0];
              end
            end else begin
              raw_bit = byte_q[bit_inc[2:0]];
            end
          end
          S_CRC: begin
            if (bit_idx == 4'd15) begin
              state_nxt   = S_EOP;
              bit_idx_nxt = 4'd0;
            end else begin
              raw_bit = ~crc[4'd15 - bit_inc];
            end
          end
          S_EOP: begin
            if (bit_idx == 4'd2) begin
              state_nxt   = S_IDLE;
              bit_idx_nxt = 4'd0;
            end
          end
          default: state_nxt = S_IDLE;
        endcase
      end
    end
  end

  // Datapath: divider, latched request, payload byte, CRC, stuff counter, NRZI
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt  <= '0;
      byte_cnt <= '0;
      size_q   <= '0;
      pid_q    <= 4'd0;
      byte_q   <= 8'd0;
      crc      <= 16'hFFFF;
      ones     <= 3'd0;
      nrzi_j   <= 1'b1;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state == S_IDLE) begin
        div_cnt <= '0;
        if (tx_start && !req_ok) err_q <= 1'b1;
        if (accept) begin
          pid_q    <= tx_pid;
          size_q   <= tx_packet_size;
          byte_cnt <= '0;
          crc      <= 16'hFFFF;
          ones     <= 3'd0;
          nrzi_j   <= ~nrzi_j;          // first SYNC bit is a 0
        end
      end else begin
        div_cnt <= bit_end ? '0 : div_cnt + DIV_W'(1);
        if (stuff_ins) begin
          nrzi_j <= ~nrzi_j;
          ones   <= 3'd0;
        end else if (adv) begin
          if (state_nxt == S_IDLE) begin
            done_q <= 1'b1;
          end else if (state_nxt == S_EOP) begin
            // NRZI level is parked at J for the final EOP bit and idle
            if (bit_idx_nxt == 4'd2) nrzi_j <= 1'b1;
          end else begin
            nrzi_j <= raw_bit ? nrzi_j : ~nrzi_j;
            ones   <= raw_bit ? ones + 3'd1 : 3'd0;
          end
          if (load_byte) begin
            byte_q   <= tx_packet_data;
            byte_cnt <= byte_cnt + SIZE_W'(1);
          end
          if (state_nxt == S_DATA) begin
            crc <= {crc[14:0], 1'b0} ^ (crc_fb ? 16'h8005 : 16'h0000);
          end
        end
      end
    end
  end

  // Outputs
  always_comb begin
    tx_transfer_active = (state != S_IDLE);
    get_tx_packet_data = load_byte;
    tx_done            = done_q;
    tx_error           = err_q;
    if (state == S_EOP && bit_idx < 4'd2) begin
      dplus_out  = 1'b0;
      dminus_out = 1'b0;
    end else begin
      dplus_out  = nrzi_j;
      dminus_out = ~nrzi_j;
    end
  end

endmodule

// File: tb/tb_usb_tx_engine.sv
// tb_usb_tx_engine: randomized scoreboard bench for usb_tx_engine.
// Stimulus pushes expected line waveforms and strobe cycles from a bit-list
// reference model; a negedge monitor captures each packet and compares on tx_done.
module tb_usb_tx_engine;

  localparam int D    = 8;
  localparam int MAXP = 64;
  localparam int SW   = $clog2(MAXP + 1);

  logic          clk;
  logic          n_rst;
  logic          tx_start;
  logic [3:0]    tx_pid;
  logic [SW-1:0] tx_packet_size;
  logic [7:0]    tx_packet_data;
  logic          get_tx_packet_data;
  logic          dplus_out, dminus_out;
  logic          tx_transfer_active, tx_done, tx_error;

  usb_tx_engine #(.CLK_DIV(D), .MAX_PAYLOAD(MAXP)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .tx_start           (tx_start),
    .tx_pid             (tx_pid),
    .tx_packet_size     (tx_packet_size),
    .tx_packet_data     (tx_packet_data),
    .get_tx_packet_data (get_tx_packet_data),
    .dplus_out          (dplus_out),
    .dminus_out         (dminus_out),
    .tx_transfer_active (tx_transfer_active),
    .tx_done            (tx_done),
    .tx_error           (tx_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // scoreboard queues: kind 1 = packet, 0 = rejected request
  logic       exp_kind[$];
  int         exp_len[$];
  logic [1:0] exp_sym[$];
  int         exp_nstb[$];
  int         exp_stb[$];
  logic [7:0] feed_q[$];
  logic [7:0] cur_pay[$];

  // monitor state
  logic [1:0] cap[$];
  int         cap_stb[$];
  logic       prev_act  = 1'b0;
  logic       prev_done = 1'b0;
  int         last_len  = 0;
  int         idle_bad  = 0;
  int         stray_get = 0;
  int         rst_bad   = 0;
  logic       popq      = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: raw bit list from the packet rules, then stuffing, NRZI, EOP.
  task automatic model_packet(input logic [3:0] pid);
    bit raw[$];
    bit first[$];
    bit wb[$];
    int stb[$];
    logic [7:0]  pb;
    logic [15:0] r;
    logic        b;
    int          ones;
    bit          line;
    pb = {~pid, pid};
    for (int i = 0; i < 8; i++) begin raw.push_back(i == 7); first.push_back(1'b0); end
    for (int i = 0; i < 8; i++) begin raw.push_back(pb[i]);  first.push_back(1'b0); end
    r = 16'hFFFF;
    foreach (cur_pay[k]) begin
      for (int i = 0; i < 8; i++) begin
        b = cur_pay[k][i];
        raw.push_back(b);
        first.push_back(i == 0);
        r = {r[14:0], 1'b0} ^ (((r[15] ^ b) == 1'b1) ? 16'h8005 : 16'h0000);
      end
    end
    if (pid == 4'h3 || pid == 4'hB)
      for (int i = 15; i >= 0; i--) begin raw.push_back(~r[i]); first.push_back(1'b0); end
    ones = 0;
    foreach (raw[j]) begin
      if (first[j]) stb.push_back(wb.size() * D);
      wb.push_back(raw[j]);
      ones = raw[j] ? ones + 1 : 0;
      if (ones == 6) begin wb.push_back(1'b0); ones = 0; end
    end
    exp_kind.push_back(1'b1);
    exp_len.push_back(wb.size() + 3);
    line = 1'b1;
    foreach (wb[j]) begin
      if (!wb[j]) line = !line;
      exp_sym.push_back(line ? 2'b10 : 2'b01);
    end
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b00);
    exp_sym.push_back(2'b10);
    exp_nstb.push_back(stb.size());
    foreach (stb[j]) exp_stb.push_back(stb[j]);
  endtask

  // mode 0 random bytes, 1 all 0xFF, 2 random with frequent 0xFF
  task automatic start_pkt(input logic [3:0] pid, input int sz, input int mode);
    logic [7:0] bv;
    cur_pay.delete();
    for (int i = 0; i < sz; i++) begin
      case (mode)
        1:       bv = 8'hFF;
        2:       bv = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        default: bv = 8'($urandom);
      endcase
      cur_pay.push_back(bv);
      feed_q.push_back(bv);
    end
    model_packet(pid);
    tx_pid         = pid;
    tx_packet_size = sz[SW-1:0];
    tx_start       = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge clk);
      if (tx_done) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no tx_done within 20000 cycles", nm);
    end
  endtask

  task automatic issue_bad(input logic [3:0] pid, input int sz, input string nm);
    exp_kind.push_back(1'b0);
    tx_pid         = pid;
    tx_packet_size = sz[SW-1:0];
    tx_start       = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    chk({nm, "_err"}, tx_error, 1);
    chk({nm, "_active"}, tx_transfer_active, 0);
    chk({nm, "_lines"}, {dplus_out, dminus_out}, 2'b10);
    @(negedge clk);
    chk({nm, "_err_one_cycle"}, tx_error, 0);
    chk({nm, "_lines_after"}, {tx_transfer_active, dplus_out, dminus_out}, 3'b010);
  endtask

  task automatic check_packet();
    logic       k;
    int         len, nexp, bad, fb_idx;
    logic [1:0] es[$];
    int         xs[$];
    vectors++;
    if (exp_kind.size() == 0 || exp_len.size() == 0) begin
      miscompares++;
      $display("FAIL pkt_kind: tx_done with no packet expected");
      return;
    end
    k = exp_kind.pop_front();
    if (k !== 1'b1) begin
      miscompares++;
      $display("FAIL pkt_kind: tx_done where a tx_error was expected");
      return;
    end
    len = exp_len.pop_front();
    for (int i = 0; i < len; i++) es.push_back(exp_sym.pop_front());
    nexp = exp_nstb.pop_front();
    for (int i = 0; i < nexp; i++) xs.push_back(exp_stb.pop_front());
    chk("pkt_cycles", cap.size(), len * D);
    bad = 0;
    fb_idx = -1;
    for (int c = 0; c < cap.size() && c < len * D; c++)
      if (cap[c] !== es[c / D]) begin
        if (bad == 0) fb_idx = c;
        bad++;
      end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL pkt_lines: %0d bad cycles, first at cycle %0d got %b expected %b",
               bad, fb_idx + 1, cap[fb_idx], es[fb_idx / D]);
    end
    chk("pkt_strobe_count", cap_stb.size(), nexp);
    bad = 0;
    for (int i = 0; i < nexp && i < cap_stb.size(); i++)
      if (cap_stb[i] != xs[i]) begin
        if (bad == 0) $display("FAIL pkt_strobe_cycle: strobe %0d at cycle %0d expected %0d",
                               i, cap_stb[i], xs[i]);
        bad++;
      end
    vectors++;
    if (bad != 0) miscompares++;
    last_len = cap.size();
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!n_rst) begin
      cap.delete();
      cap_stb.delete();
      prev_act  = 1'b0;
      prev_done = 1'b0;
      if (dplus_out !== 1'b1 || dminus_out !== 1'b0 || tx_transfer_active || tx_done ||
          tx_error || get_tx_packet_data) rst_bad++;
    end else begin
      if (tx_error) begin
        vectors++;
        if (exp_kind.size() == 0) begin
          miscompares++;
          $display("FAIL err_kind: tx_error with nothing expected");
        end else if (exp_kind.pop_front() !== 1'b0) begin
          miscompares++;
          $display("FAIL err_kind: tx_error where a packet was expected");
        end
      end
      if (tx_transfer_active) begin
        if (!prev_act) begin
          cap.delete();
          cap_stb.delete();
        end
        cap.push_back({dplus_out, dminus_out});
        if (get_tx_packet_data) cap_stb.push_back(cap.size());
      end else begin
        if (get_tx_packet_data) stray_get++;
        if ({dplus_out, dminus_out} !== 2'b10) idle_bad++;
      end
      if (tx_done && prev_done) idle_bad++;
      if (tx_done) check_packet();
      prev_act  = tx_transfer_active;
      prev_done = tx_done;
    end
  end

  // FIFO model: head byte presented, popped after each sampled strobe
  always @(negedge clk) begin
    if (!n_rst) begin
      popq = 1'b0;
    end else begin
      if (popq && feed_q.size() > 0) void'(feed_q.pop_front());
      popq = get_tx_packet_data;
    end
    tx_packet_data = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
  end

  initial begin
    logic [3:0] pids[5];
    logic [3:0] p;
    int         sz;
    pids = '{4'h3, 4'hB, 4'h2, 4'hA, 4'hE};
    n_rst          = 1'b1;
    tx_start       = 1'b0;
    tx_pid         = 4'h0;
    tx_packet_size = '0;
    #2 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dplus", dplus_out, 1);
    chk("rst_dminus", dminus_out, 0);
    chk("rst_active", tx_transfer_active, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_error", tx_error, 0);
    chk("rst_get", get_tx_packet_data, 0);
    n_rst = 1'b1;
    @(negedge clk);

    start_pkt(4'h2, 0, 0);
    chk("ack_first_sync_k", {tx_transfer_active, dplus_out, dminus_out}, 3'b101);
    wait_done("ack");
    #1 chk("ack_cycles", last_len, 19 * D);
    @(negedge clk);

    start_pkt(4'h3, 0, 0);
    wait_done("data0_empty");
    #1 chk("data0_empty_cycles", last_len, 35 * D);
    @(negedge clk);

    issue_bad(4'h1, 0, "bad_pid");
    issue_bad(4'hA, 3, "nak_size");
    issue_bad(4'h3, MAXP + 1, "oversize");

    // tx_start while busy is ignored; next packet starts in the tx_done cycle
    start_pkt(4'h3, 6, 0);
    repeat (24 * D) @(negedge clk);
    tx_pid = 4'hB; tx_packet_size = 3; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    wait_done("busy_data0");
    start_pkt(4'hB, 4, 1);
    chk("b2b_first_sync", {tx_transfer_active, dplus_out, dminus_out}, 3'b101);
    wait_done("data1_ff");

    for (int it = 0; it < 16; it++) begin
      p  = pids[$urandom_range(0, 4)];
      sz = (p == 4'h3 || p == 4'hB) ? int'($urandom_range(0, 12)) : 0;
      start_pkt(p, sz, 2);
      wait_done("rand");
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    @(negedge clk);
    start_pkt(4'h3, MAXP, 2);
    wait_done("max_payload");
    @(negedge clk);

    // reset mid-payload
    start_pkt(4'h3, 8, 0);
    repeat (30 * D) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst_lines", {dplus_out, dminus_out}, 2'b10);
    chk("midrst_active", tx_transfer_active, 0);
    chk("midrst_get", get_tx_packet_data, 0);
    chk("midrst_done_err", {tx_done, tx_error}, 2'b00);
    exp_kind.delete(); exp_len.delete(); exp_sym.delete();
    exp_nstb.delete(); exp_stb.delete(); feed_q.delete();
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    start_pkt(4'h2, 0, 0);
    wait_done("ack_after_reset");
    #1 chk("ack_after_reset_cycles", last_len, 19 * D);
    repeat (4) @(negedge clk);

    chk("idle_lines_j", idle_bad, 0);
    chk("stray_strobes", stray_get, 0);
    chk("reset_outputs", rst_bad, 0);
    chk("expect_queue_empty", exp_kind.size(), 0);
    chk("fifo_drained", feed_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
